hsid_replay_fifo: RTL and testbench
===================================

// Module: hsid_replay_fifo
// PURPOSE
//  Multi-lane synchronous FIFO for HSID pixel/reference streaming, with counted replay: on request
//  the stored contents are re-emitted a programmable number of passes without being consumed, then the
//  block returns to normal FIFO operation. Sits between the AXI/OBI data loader and the distance datapath.
//  Adds almost_empty, level, 1-cycle read valid and flow-controlled replay to the single-lane FIFO.
// PARAMETERS
//  WORD_WIDTH      HSID_WORD_WIDTH           bits per lane
//  NUM_LANES       2                         parallel lanes sharing one pointer set (entry = NUM_LANES*WORD_WIDTH)
//  FIFO_ADDR_WIDTH HSID_FIFO_ADDR_WIDTH      depth = 2**FIFO_ADDR_WIDTH entries
//  LOOP_CNT_WIDTH  HSID_FIFO_LOOP_CNT_WIDTH  width of replay pass counter
// PORTS
//  clk                    in  1        clock, rising edge
//  rst_n                  in  1        asynchronous active-low reset
//  clear                  in  1        synchronous flush, highest priority after reset
//  wr_en                  in  1        push request
//  data_in                in  L*W      push entry, lane 0 in LSBs
//  rd_en                  in  1        pop request (also advances replay)
//  data_out               out L*W      registered read entry
//  data_out_valid         out 1        data_out updated this cycle
//  level                  out AW+1     current occupancy 0..depth
//  almost_full_threshold  in  AW+1     almost_full  = level >= threshold
//  almost_empty_threshold in  AW+1     almost_empty = level <= threshold
//  full / almost_full / empty / almost_empty  out 1 each  status flags
//  loop_start             in  1        replay request pulse
//  loop_passes            in  LCW      number of replay passes, sampled with loop_start
//  loop_busy              out 1        replay in progress
//  loop_done              out 1        1-cycle pulse at replay completion
//  overflow / underflow   out 1 each   sticky error flags (HSID_FIFO_ERR_FLAGS_EN only)
// BEHAVIOUR
//  - Reset: pointers, level, counters 0; data_out 0; data_out_valid/loop_busy/loop_done 0; empty 1; state NORMAL.
//  - clear: as reset except memory contents untouched; aborts replay, no loop_done; clears sticky flags.
//  - Memory not reset; only pointers define validity.
//  - FSM NORMAL: push accepted iff wr_en && !full; pop accepted iff rd_en && !empty. Pop: data_out <= mem[rd_ptr]
//    at next edge, data_out_valid high that cycle (1-cycle latency). Push+pop same cycle: level unchanged.
//    At full, simultaneous push+pop both accepted. At empty, push+pop -> push only, pop rejected.
//  - Pointers AW bits, wrap naturally at depth; level AW+1 bits, never exceeds depth nor underflows.
//  - NORMAL->LOOP on loop_start && !empty && loop_passes!=0: latch loop_len<=level, passes<=loop_passes,
//    word_cnt<=0, pass_cnt<=0, loop_busy<=1. loop_start with empty FIFO: ignored. loop_passes==0 with
//    non-empty FIFO: no state change, loop_done pulses next cycle.
//  - LOOP: full forced 1 (producers stall), wr_en dropped. Each cycle with rd_en: data_out<=mem[rd_ptr],
//    mem[wr_ptr]<=mem[rd_ptr], both pointers +1, level unchanged, data_out_valid 1. word_cnt wraps at
//    loop_len-1 incrementing pass_cnt; on last word of last pass: loop_done 1 same cycle as that data_out_valid,
//    loop_busy 0, ->NORMAL. Order after replay identical to before. rd_en low: replay stalls, no output.
//  - loop_start during LOOP ignored. Reset mid-replay: returns to reset state immediately.
// CONFIGURATION
//  HSID_FIFO_ERR_FLAGS_EN defined: overflow set on wr_en while full (incl. forced full in LOOP), underflow on
//  rd_en while empty in NORMAL; both sticky until clear/reset. Undefined: both tied 0, no extra flops.
// STRUCTURE
//  hsid_pkg: HSID_FIFO_LOOP_CNT_WIDTH (8); typedef enum logic {HSID_FIFO_NORMAL, HSID_FIFO_LOOP} hsid_fifo_state_t.
//  Sub-module hsid_fifo_mem: simple dual-port RAM, sync write, registered read, no reset. Top holds FSM,
//  pointers, counters, flags.
// TESTING (W=16, L=2, AW=3, depth 8, ERR_FLAGS_EN defined)
//  1 Reset -> empty=1, level=0, full=0, data_out=0, data_out_valid=0, loop_busy=0.
//  2 Push 0x0001..0x0008 -> full=1 at level 8; 9th push dropped, overflow=1; 8 pops give 0x0001..0x0008 in order,
//    each 1 cycle after rd_en.
//  3 af_thr=6, ae_thr=2: after 6 pushes almost_full=1; pop down to level 2 -> almost_empty=1, level=2.
//  4 Push A,B,C; loop_start, passes=2, rd_en high -> A,B,C,A,B,C, loop_done with 2nd C, level stays 3; then
//    pops give A,B,C, empty=1.
//  5 Replay passes=3 of 4 entries, clear after 2 outputs -> level 0, empty=1, loop_busy=0, loop_done never pulses.
//  6 Full + push 0x9 & pop same cycle -> level 8, oldest out, 0x9 last; empty + push & pop -> level 1, underflow=1.

Source files
------------

// File: rtl/hsid_pkg.sv
// ============================================================================
// Module  : hsid_pkg
// Brief   : Shared HSID FIFO constants and the replay FIFO state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hsid_pkg;

    localparam int HSID_WORD_WIDTH          = 16;
    localparam int HSID_FIFO_ADDR_WIDTH     = 4;
    localparam int HSID_FIFO_LOOP_CNT_WIDTH = 8;

    typedef enum logic {
        HSID_FIFO_NORMAL = 1'b0,
        HSID_FIFO_LOOP   = 1'b1
    } hsid_fifo_state_t;

endpackage

`default_nettype wire

// File: rtl/hsid_replay_fifo_if.sv
// ============================================================================
// Module  : hsid_replay_fifo_if
// Brief   : Push/pop, status and replay-control bundle of the replay FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hsid_replay_fifo_if #(
    parameter int WORD_WIDTH      = hsid_pkg::HSID_WORD_WIDTH,
    parameter int NUM_LANES       = 2,
    parameter int FIFO_ADDR_WIDTH = hsid_pkg::HSID_FIFO_ADDR_WIDTH,
    parameter int LOOP_CNT_WIDTH  = hsid_pkg::HSID_FIFO_LOOP_CNT_WIDTH
);
    logic                              clear;
    logic                              wr_en;
    logic [NUM_LANES*WORD_WIDTH-1:0]   data_in;
    logic                              rd_en;
    logic [NUM_LANES*WORD_WIDTH-1:0]   data_out;
    logic                              data_out_valid;
    logic [FIFO_ADDR_WIDTH:0]          level;
    logic [FIFO_ADDR_WIDTH:0]          almost_full_threshold;
    logic [FIFO_ADDR_WIDTH:0]          almost_empty_threshold;
    logic                              full;
    logic                              almost_full;
    logic                              empty;
    logic                              almost_empty;
    logic                              loop_start;
    logic [LOOP_CNT_WIDTH-1:0]         loop_passes;
    logic                              loop_busy;
    logic                              loop_done;
    logic                              overflow;
    logic                              underflow;

    modport master (
        output clear, wr_en, data_in, rd_en, almost_full_threshold,
               almost_empty_threshold, loop_start, loop_passes,
        input  data_out, data_out_valid, level, full, almost_full, empty,
               almost_empty, loop_busy, loop_done, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en, almost_full_threshold,
               almost_empty_threshold, loop_start, loop_passes,
        output data_out, data_out_valid, level, full, almost_full, empty,
               almost_empty, loop_busy, loop_done, overflow, underflow
    );

endinterface

`default_nettype wire

// File: rtl/hsid_fifo_mem.sv
// ============================================================================
// Module  : hsid_fifo_mem
// Brief   : Simple dual-port RAM, synchronous write, registered read, no reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hsid_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Read-during-write to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/hsid_replay_fifo.sv
// ============================================================================
// Module  : hsid_replay_fifo
// Brief   : Multi-lane FIFO with counted, non-consuming replay of its contents.
//           Optional sticky overflow/underflow flags: HSID_FIFO_ERR_FLAGS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hsid_replay_fifo
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH      = HSID_WORD_WIDTH,
    parameter int NUM_LANES       = 2,
    parameter int FIFO_ADDR_WIDTH = HSID_FIFO_ADDR_WIDTH,
    parameter int LOOP_CNT_WIDTH  = HSID_FIFO_LOOP_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    hsid_replay_fifo_if.slave bus
);
    localparam int          DW        = WORD_WIDTH * NUM_LANES;
    localparam int          AW        = FIFO_ADDR_WIDTH;
    localparam int          LCW       = LOOP_CNT_WIDTH;
    localparam logic [AW:0] DEPTH_LVL = {1'b1, {AW{1'b0}}};

    hsid_fifo_state_t state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [AW:0]      loop_len_q, loop_len_d;
    logic [AW-1:0]    word_cnt_q, word_cnt_d;
    logic [LCW-1:0]   passes_q, passes_d;
    logic [LCW-1:0]   pass_cnt_q, pass_cnt_d;
    logic             loop_busy_q, loop_busy_d;
    logic             loop_done_q, loop_done_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_seen_q, dout_seen_d;

    logic             w_loop, w_full_lvl, w_empty;
    logic             w_start_ok, w_loop_go, w_push, w_pop, w_step;
    logic             w_last_word, w_last_pass;
    logic [DW-1:0]    mem_rd_data;
    logic [AW-1:0]    mem_rd_addr;
    logic             mem_rd_en, mem_wr_en;

    always_comb begin
        w_loop      = (state_q == HSID_FIFO_LOOP);
        w_full_lvl  = (level_q == DEPTH_LVL);
        w_empty     = (level_q == '0);
        w_start_ok  = !w_loop && bus.loop_start && !w_empty;
        w_loop_go   = w_start_ok && (bus.loop_passes != '0);
        // The cycle that enters replay performs no push or pop, so the replay
        // length is exactly the occupancy seen by the requester.
        w_pop       = !w_loop && !w_loop_go && bus.rd_en && !w_empty;
        w_push      = !w_loop && !w_loop_go && bus.wr_en && (!w_full_lvl || w_pop);
        w_step      = w_loop && bus.rd_en;
        w_last_word = ({1'b0, word_cnt_q} == (loop_len_q - 1'b1));
        w_last_pass = (pass_cnt_q == (passes_q - 1'b1));
    end

    // Replay reads through an offset from rd_ptr instead of copying entries to
    // the tail; the stored order afterwards is identical and nothing is consumed.
    assign mem_rd_addr = w_loop ? (rd_ptr_q + word_cnt_q) : rd_ptr_q;
    assign mem_rd_en   = w_pop || w_step;
    assign mem_wr_en   = w_push && !bus.clear;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        loop_len_d   = loop_len_q;
        word_cnt_d   = word_cnt_q;
        passes_d     = passes_q;
        pass_cnt_d   = pass_cnt_q;
        loop_busy_d  = loop_busy_q;
        loop_done_d  = 1'b0;
        dout_valid_d = w_pop || w_step;
        dout_seen_d  = dout_seen_q || dout_valid_d;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (w_loop_go) begin
            state_d     = HSID_FIFO_LOOP;
            loop_len_d  = level_q;
            passes_d    = bus.loop_passes;
            word_cnt_d  = '0;
            pass_cnt_d  = '0;
            loop_busy_d = 1'b1;
        end else if (w_start_ok) begin
            loop_done_d = 1'b1;
        end

        if (w_step) begin
            if (w_last_word) begin
                word_cnt_d = '0;
                if (w_last_pass) begin
                    state_d     = HSID_FIFO_NORMAL;
                    pass_cnt_d  = '0;
                    loop_busy_d = 1'b0;
                    loop_done_d = 1'b1;
                end else begin
                    pass_cnt_d = pass_cnt_q + 1'b1;
                end
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        if (bus.clear) begin
            state_d      = HSID_FIFO_NORMAL;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            loop_len_d   = '0;
            word_cnt_d   = '0;
            passes_d     = '0;
            pass_cnt_d   = '0;
            loop_busy_d  = 1'b0;
            loop_done_d  = 1'b0;
            dout_valid_d = 1'b0;
            dout_seen_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HSID_FIFO_NORMAL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            loop_len_q   <= '0;
            word_cnt_q   <= '0;
            passes_q     <= '0;
            pass_cnt_q   <= '0;
            loop_busy_q  <= 1'b0;
            loop_done_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            loop_len_q   <= loop_len_d;
            word_cnt_q   <= word_cnt_d;
            passes_q     <= passes_d;
            pass_cnt_q   <= pass_cnt_d;
            loop_busy_q  <= loop_busy_d;
            loop_done_q  <= loop_done_d;
            dout_valid_q <= dout_valid_d;
            dout_seen_q  <= dout_seen_d;
        end
    end

`ifdef HSID_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q || (bus.wr_en && (w_loop || w_full_lvl) && !w_push);
        underflow_d = underflow_q || (!w_loop && bus.rd_en && w_empty);
        if (bus.clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    hsid_fifo_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // RAM output is unreset, so hide it until a read has landed since reset/clear.
    assign bus.data_out       = dout_seen_q ? mem_rd_data : '0;
    assign bus.data_out_valid = dout_valid_q;
    assign bus.level          = level_q;
    assign bus.full           = w_loop || w_full_lvl;
    assign bus.empty          = w_empty;
    assign bus.almost_full    = (level_q >= bus.almost_full_threshold);
    assign bus.almost_empty   = (level_q <= bus.almost_empty_threshold);
    assign bus.loop_busy      = loop_busy_q;
    assign bus.loop_done      = loop_done_q;

endmodule

`default_nettype wire

// File: tb/tb_hsid_replay_fifo.sv
// ============================================================================
// Module  : tb_hsid_replay_fifo
// Brief   : Directed table-driven bench for hsid_replay_fifo (W=16, L=2, depth 8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsid_replay_fifo;

`ifdef HSID_FIFO_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic        exp_v;
        logic [15:0] exp_d;
        logic [3:0]  exp_lvl;
        logic        exp_full;
        logic        exp_empty;
        logic        exp_af;
        logic        exp_ae;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tv [37];

    hsid_replay_fifo_if #(
        .WORD_WIDTH(16), .NUM_LANES(2), .FIFO_ADDR_WIDTH(3), .LOOP_CNT_WIDTH(8)
    ) bus ();

    hsid_replay_fifo #(
        .WORD_WIDTH(16), .NUM_LANES(2), .FIFO_ADDR_WIDTH(3), .LOOP_CNT_WIDTH(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ent(input logic [15:0] v);
        return {~v, v};
    endfunction

    function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] din,
                                input logic v, input logic [15:0] d, input int lvl);
        vec_t t;
        t.wr        = wr;
        t.rd        = rd;
        t.din       = din;
        t.exp_v     = v;
        t.exp_d     = d;
        t.exp_lvl   = 4'(lvl);
        t.exp_full  = (lvl == 8);
        t.exp_empty = (lvl == 0);
        t.exp_af    = (lvl >= 6);
        t.exp_ae    = (lvl <= 2);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        bus.wr_en   = 1'b1;
        bus.data_in = ent(v);
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [15:0] v);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk({name, "_valid"}, 32'(bus.data_out_valid), 32'd1);
        chk({name, "_data"}, bus.data_out, ent(v));
    endtask

    initial begin
        logic [15:0] abc [3];
        abc[0] = 16'h000A;
        abc[1] = 16'h000B;
        abc[2] = 16'h000C;

        // Fill, overflow, drain; then full push+pop and empty push+pop.
        for (int i = 0; i < 8; i++) tv[i] = mk(1, 0, 16'(i + 1), 0, 0, i + 1);
        tv[8] = mk(1, 0, 16'h0099, 0, 0, 8);
        for (int i = 0; i < 8; i++) tv[9 + i] = mk(0, 1, 0, 1, 16'(i + 1), 7 - i);
        tv[17] = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tv[18 + i] = mk(1, 0, 16'(16'h11 + i), 0, 0, i + 1);
        tv[26] = mk(1, 1, 16'h0019, 1, 16'h0011, 8);
        for (int i = 0; i < 8; i++) tv[27 + i] = mk(0, 1, 0, 1, 16'(16'h12 + i), 7 - i);
        tv[35] = mk(1, 1, 16'h0020, 0, 0, 1);
        tv[36] = mk(0, 1, 0, 1, 16'h0020, 0);

        bus.clear                  = 1'b0;
        bus.wr_en                  = 1'b0;
        bus.rd_en                  = 1'b0;
        bus.data_in                = '0;
        bus.almost_full_threshold  = 4'd6;
        bus.almost_empty_threshold = 4'd2;
        bus.loop_start             = 1'b0;
        bus.loop_passes            = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_dout", bus.data_out, 32'd0);
        chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
        chk("rst_busy", 32'(bus.loop_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 37; i++) begin
            bus.wr_en   = tv[i].wr;
            bus.rd_en   = tv[i].rd;
            bus.data_in = ent(tv[i].din);
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus.data_out_valid), 32'(tv[i].exp_v));
            if (tv[i].exp_v)
                chk($sformatf("v%0d_data", i), bus.data_out, ent(tv[i].exp_d));
            chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(tv[i].exp_lvl));
            chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(tv[i].exp_full));
            chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(tv[i].exp_empty));
            chk($sformatf("v%0d_afull", i), 32'(bus.almost_full), 32'(tv[i].exp_af));
            chk($sformatf("v%0d_aempty", i), 32'(bus.almost_empty), 32'(tv[i].exp_ae));
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("overflow_sticky", 32'(bus.overflow), 32'(ERR));
        chk("underflow_sticky", 32'(bus.underflow), 32'(ERR));

        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_overflow", 32'(bus.overflow), 32'd0);
        chk("clr_underflow", 32'(bus.underflow), 32'd0);
        chk("clr_dout", bus.data_out, 32'd0);
        chk("clr_empty", 32'(bus.empty), 32'd1);

        // Two-pass replay of A,B,C with producer held off.
        for (int i = 0; i < 3; i++) push(abc[i]);
        bus.loop_start  = 1'b1;
        bus.loop_passes = 8'd2;
        step();
        bus.loop_start  = 1'b0;
        chk("lp_busy", 32'(bus.loop_busy), 32'd1);
        chk("lp_full", 32'(bus.full), 32'd1);
        chk("lp_valid0", 32'(bus.data_out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            bus.rd_en   = 1'b1;
            bus.wr_en   = 1'b1;
            bus.data_in = ent(16'h00EE);
            step();
            chk($sformatf("lp%0d_valid", i), 32'(bus.data_out_valid), 32'd1);
            chk($sformatf("lp%0d_data", i), bus.data_out, ent(abc[i % 3]));
            chk($sformatf("lp%0d_level", i), 32'(bus.level), 32'd3);
            chk($sformatf("lp%0d_done", i), 32'(bus.loop_done), 32'(i == 5));
            chk($sformatf("lp%0d_busy", i), 32'(bus.loop_busy), 32'(i != 5));
        end
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        step();
        chk("lp_done_pulse", 32'(bus.loop_done), 32'd0);
        chk("lp_after_full", 32'(bus.full), 32'd0);
        chk("lp_after_level", 32'(bus.level), 32'd3);
        chk("lp_overflow", 32'(bus.overflow), 32'(ERR));
        for (int i = 0; i < 3; i++) pop_chk($sformatf("lp_pop%0d", i), abc[i]);
        chk("lp_pop_empty", 32'(bus.empty), 32'd1);

        // Zero passes on a non-empty FIFO: immediate done, no replay.
        push(16'h0044);
        bus.loop_start  = 1'b1;
        bus.loop_passes = 8'd0;
        step();
        bus.loop_start  = 1'b0;
        chk("zp_done", 32'(bus.loop_done), 32'd1);
        chk("zp_busy", 32'(bus.loop_busy), 32'd0);
        step();
        chk("zp_done_pulse", 32'(bus.loop_done), 32'd0);
        pop_chk("zp_pop", 16'h0044);

        // Clear aborts a replay mid-pass without loop_done.
        for (int i = 0; i < 4; i++) push(16'(16'h51 + i));
        bus.loop_start  = 1'b1;
        bus.loop_passes = 8'd3;
        step();
        bus.loop_start  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.rd_en = 1'b1;
            step();
            chk($sformatf("ab%0d_data", i), bus.data_out, ent(16'(16'h51 + i)));
        end
        bus.rd_en = 1'b0;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("ab_level", 32'(bus.level), 32'd0);
        chk("ab_empty", 32'(bus.empty), 32'd1);
        chk("ab_busy", 32'(bus.loop_busy), 32'd0);
        chk("ab_done", 32'(bus.loop_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ab_nodone%0d", i), 32'(bus.loop_done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
